// File: rtl/and4_result_fifo.sv
// -----------------------------------------------------------------------------
// and4_result_fifo
//
// Accepts operand pairs (a, b) on a valid/ready handshake, computes a & b at
// write time and buffers the results in a DEPTH-entry FIFO. Results leave in
// acceptance order on a second valid/ready handshake, so the operand source
// can run ahead of a consumer that stalls.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operand pair on a/b is valid
//   in_ready   block can accept a pair this cycle (registered state only)
//   a, b       operands, WIDTH bits
//   out_valid  y holds a valid result
//   out_ready  consumer takes y this cycle
//   y          head-of-FIFO result (show-ahead)
//   count      current occupancy, 0..DEPTH
//   acc_cnt    saturating count of accepted pushes
//              (present only when AND4_RESULT_FIFO_STATS_EN is defined)
//
// Parameters:
//   WIDTH  operand/result width
//   DEPTH  FIFO entries, power of 2, minimum 2
// -----------------------------------------------------------------------------
module and4_result_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             y,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef AND4_RESULT_FIFO_STATS_EN
  ,
  output logic [15:0]                  acc_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // Handshake status comes straight from the occupancy register, so there is
  // no combinational path from out_ready to in_ready. A slot freed by a pop
  // while full becomes visible upstream one cycle later.
  assign in_ready  = (count != FULL_COUNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Storage is unreset, so mask the head while empty: y reads 0 out of reset
  // and never shows X from uninitialised entries.
  assign y = out_valid ? mem[rd_ptr] : '0;

  // NOTE: the storage array has no reset; clearing it would cost a reset net
  // on every bit and buys nothing, since occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= a & b;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of 2, so pointer wrap is the natural rollover.
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef AND4_RESULT_FIFO_STATS_EN
  // Saturates instead of wrapping so a long run never reads back as small.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt <= '0;
    end else if (push && (acc_cnt != 16'hFFFF)) begin
      acc_cnt <= acc_cnt + 16'd1;
    end
  end
`endif

endmodule
